// File: rtl/state_encoder.sv
// state_encoder: five-state step/select encoder with button synchronizer.
// Optional button debounce filter enabled by defining STATE_ENCODER_DEBOUNCE_EN.
module state_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       sel_valid,
  input  logic [4:0] sel_onehot,
  output logic [2:0] state,
  output logic       state_changed,
  output logic       sel_err
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  // Reject a zero-length filter at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic       sync1_q;
  logic       sync2_q;
  logic [1:0] vld_q;
  logic       sync_ok;
  logic       filt;
  logic       prev_q;
  logic       step_req;

  // Two-flop synchronizer plus a marker for when its output is a real sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= btn_next;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // The reset contents of the synchronizer are not an observation of the pin.
  assign sync_ok = vld_q[1];

`ifdef STATE_ENCODER_DEBOUNCE_EN
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Accept a new level only after it has held for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (sync_ok && (sync2_q != filt_q)) begin
      if (cnt_q == CNT_LAST) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign filt = filt_q;
`else
  // Without filtering, the level is the synchronized pin once it is valid.
  assign filt = sync_ok ? sync2_q : 1'b1;
`endif

  // Rising-edge history of the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= filt;
  end

  assign step_req = filt & ~prev_q;

  logic       sel_one;
  logic       sel_ok;
  logic       sel_bad;
  logic [2:0] sel_idx;
  state_t     state_q;
  state_t     state_d;

  assign sel_one = $onehot(sel_onehot);
  assign sel_ok  = sel_valid & sel_one;
  assign sel_bad = sel_valid & ~sel_one;

  // Bit index of a one-hot request; only used when exactly one bit is set.
  assign sel_idx[0] = sel_onehot[1] | sel_onehot[3];
  assign sel_idx[1] = sel_onehot[2] | sel_onehot[3];
  assign sel_idx[2] = sel_onehot[4];

  // Next state: legal select wins, then step with wrap, else hold.
  always_comb begin
    state_d = state_q;
    if (sel_ok) begin
      unique case (sel_idx)
        3'd0:    state_d = S0;
        3'd1:    state_d = S1;
        3'd2:    state_d = S2;
        3'd3:    state_d = S3;
        default: state_d = S4;
      endcase
    end else if (step_req) begin
      unique case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        S3:      state_d = S4;
        default: state_d = S0;
      endcase
    end
  end

  // State register with registered change and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S0;
      state_changed <= 1'b0;
      sel_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      state_changed <= (state_d != state_q);
      sel_err       <= sel_bad;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_state_encoder.sv
// tb_state_encoder: directed scoreboard bench for state_encoder.
// Works with and without STATE_ENCODER_DEBOUNCE_EN (DEBOUNCE_CYCLES = 8).
module tb_state_encoder;

`ifdef STATE_ENCODER_DEBOUNCE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       rst;
  logic       btn_next;
  logic       sel_valid;
  logic [4:0] sel_onehot;
  logic [2:0] state;
  logic       state_changed;
  logic       sel_err;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       ch;
    logic       er;
  } exp_t;

  exp_t sb[$];

  state_encoder #(.DEBOUNCE_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .sel_valid    (sel_valid),
    .sel_onehot   (sel_onehot),
    .state        (state),
    .state_changed(state_changed),
    .sel_err      (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e, input string tag);
    n_assert++;
    assert (state === e.st) else begin
      n_fail++;
      $error("FAIL %s state got %0d want %0d", tag, state, e.st);
    end
    n_assert++;
    assert (state_changed === e.ch) else begin
      n_fail++;
      $error("FAIL %s state_changed got %0b want %0b",
             tag, state_changed, e.ch);
    end
    n_assert++;
    assert (sel_err === e.er) else begin
      n_fail++;
      $error("FAIL %s sel_err got %0b want %0b", tag, sel_err, e.er);
    end
  endtask

  // Push expectation for the next edge, clock, then pop and compare.
  task automatic cyc(input logic [2:0] st, input logic ch,
                     input logic er, input string tag);
    exp_t e;
    e.st = st;
    e.ch = ch;
    e.er = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e, tag);
  endtask

  task automatic press(input logic [2:0] from, input logic [2:0] to,
                       input string tag);
    btn_next = 1'b1;
    repeat (LAT - 1) cyc(from, 1'b0, 1'b0, tag);
    cyc(to, 1'b1, 1'b0, tag);
    btn_next = 1'b0;
    repeat (LAT + 1) cyc(to, 1'b0, 1'b0, tag);
  endtask

  task automatic sel(input logic [4:0] oh, input logic [2:0] st,
                     input logic ch, input logic er, input string tag);
    sel_valid  = 1'b1;
    sel_onehot = oh;
    cyc(st, ch, er, tag);
    sel_valid  = 1'b0;
    sel_onehot = 5'b00000;
    cyc(st, 1'b0, 1'b0, tag);
  endtask

  initial begin
    exp_t z;
    z = '0;
    rst        = 1'b1;
    btn_next   = 1'b0;
    sel_valid  = 1'b0;
    sel_onehot = 5'b00000;
    #2;
    check(z, "reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 1) cyc(3'd0, 1'b0, 1'b0, "settle");

`ifdef STATE_ENCODER_DEBOUNCE_EN
    for (int g = 0; g < 2; g++) begin
      btn_next = 1'b1;
      repeat (3) cyc(3'd0, 1'b0, 1'b0, "glitch");
      btn_next = 1'b0;
      repeat (4) cyc(3'd0, 1'b0, 1'b0, "glitch");
    end
`endif

    press(3'd0, 3'd1, "step1");
    press(3'd1, 3'd2, "step2");
    press(3'd2, 3'd3, "step3");
    press(3'd3, 3'd4, "step4");
    press(3'd4, 3'd0, "wrap");
    press(3'd0, 3'd1, "step6");

    sel(5'b01000, 3'd3, 1'b1, 1'b0, "sel3");
    sel(5'b01000, 3'd3, 1'b0, 1'b0, "sel3_again");
    sel(5'b00110, 3'd3, 1'b0, 1'b1, "sel_multi");
    sel(5'b00000, 3'd3, 1'b0, 1'b1, "sel_zero");

    sel_onehot = 5'b00001;
    cyc(3'd3, 1'b0, 1'b0, "sel_ignored");
    sel_onehot = 5'b00000;

    sel(5'b00100, 3'd2, 1'b1, 1'b0, "sel2");

    btn_next = 1'b1;
    repeat (LAT - 1) cyc(3'd2, 1'b0, 1'b0, "prio");
    sel_valid  = 1'b1;
    sel_onehot = 5'b10000;
    cyc(3'd4, 1'b1, 1'b0, "prio_hit");
    sel_valid  = 1'b0;
    sel_onehot = 5'b00000;
    btn_next   = 1'b0;
    repeat (LAT + 1) cyc(3'd4, 1'b0, 1'b0, "prio_after");

    btn_next = 1'b1;
    repeat (LAT - 1) cyc(3'd4, 1'b0, 1'b0, "bad_step");
    sel_valid  = 1'b1;
    sel_onehot = 5'b00011;
    cyc(3'd0, 1'b1, 1'b1, "bad_step_hit");
    sel_valid  = 1'b0;
    sel_onehot = 5'b00000;
    btn_next   = 1'b0;
    repeat (LAT + 1) cyc(3'd0, 1'b0, 1'b0, "bad_step_after");

    press(3'd0, 3'd1, "pre_rst");
    btn_next = 1'b1;
    cyc(3'd1, 1'b0, 1'b0, "held");
    rst = 1'b1;
    #2;
    check(z, "async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 4) cyc(3'd0, 1'b0, 1'b0, "held_rst");
    btn_next = 1'b0;
    repeat (LAT + 1) cyc(3'd0, 1'b0, 1'b0, "release");
    press(3'd0, 3'd1, "repress");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/state_encoder.md
STATE_ENCODER -- requirements
Module: state_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of stable synchronized cycles needed to accept a btn_next level change (debounce only).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port btn_next  input  1  raw asynchronous step button, active-high.
REQ-005 SHALL have port sel_valid  input  1  direct-select strobe, synchronous to clk.
REQ-006 SHALL have port sel_onehot  input  5  one-hot direct-select request; bit i selects state code i.
REQ-007 SHALL have port state  output  3  registered state code, legal values 0..4; 4 is encoded 3'b100.
REQ-008 SHALL have port state_changed  output  1  registered one-cycle pulse, high in the first cycle a new state value is presented.
REQ-009 SHALL have port sel_err  output  1  registered one-cycle pulse flagging an illegal direct-select request.

Function
REQ-010 SHALL pass btn_next through a 2-flop synchronizer before any use.
REQ-011 SHALL detect a step request on a 0->1 transition of the filtered button level (see REQ-022/023).
REQ-012 SHALL advance state by 1 on a step request: 0->1->2->3->4->0, with wrap from 4 to 0.
REQ-013 SHALL treat sel_valid=1 with exactly one sel_onehot bit set as a legal select and load state with that bit's index at the next clk edge.
REQ-014 SHALL give a legal select priority over a step request in the same cycle; the step request is discarded, not deferred.
REQ-015 SHALL treat sel_valid=1 with zero or more than one sel_onehot bit set as illegal: state is not loaded from sel_onehot and sel_err pulses for exactly one cycle.
REQ-016 SHALL still apply a step request that coincides with an illegal select.
REQ-017 SHALL ignore sel_onehot whenever sel_valid=0.
REQ-018 SHALL pulse state_changed only when the state value actually differs; a legal select of the current state gives no pulse.
REQ-019 SHALL, without debounce, update state on the 3rd rising clk edge after btn_next rises, given setup is met.
REQ-020 SHALL never present a state value outside 0..4.
REQ-021 SHALL generate one step per press; holding btn_next high produces no further steps.

Configuration
REQ-022 SHALL, with macro STATE_ENCODER_DEBOUNCE_EN defined, update the filtered level only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count, and step latency becomes 3+DEBOUNCE_CYCLES cycles.
REQ-023 SHALL, with STATE_ENCODER_DEBOUNCE_EN undefined, make the filtered level equal the synchronized level, omit the debounce counter, and ignore DEBOUNCE_CYCLES.

Reset
REQ-024 SHALL, while rst=1, force state=0, state_changed=0, sel_err=0, synchronizer flops=0 and the debounce counter=0, independent of clk.
REQ-025 SHALL reset the edge-detect history and filtered level to 1, so a button held through reset release produces no step until it is released and pressed again.
REQ-026 SHALL discard any step or select in progress when rst asserts mid-operation; after release, operation starts from state 0.

Verification
REQ-027 SHALL be verified (debounce off): after reset, 6 clean btn_next pulses -> state 1,2,3,4,0,1; each update 3 edges after the rise; state_changed pulses 6 times.
REQ-028 SHALL be verified: sel_valid=1, sel_onehot=5'b01000 from state 1 -> state=3 next edge, state_changed=1 for one cycle; repeating it -> state stays 3, no pulse.
REQ-029 SHALL be verified: sel_onehot=5'b00110 and then 5'b00000 with sel_valid=1 -> sel_err pulses once for each, state unchanged.
REQ-030 SHALL be verified: legal select 5'b10000 in the same cycle as a step request from state 2 -> state=4, never 3.
REQ-031 SHALL be verified: btn_next held high across rst release -> state stays 0; release then press -> state=1.
REQ-032 SHALL be verified (debounce on, DEBOUNCE_CYCLES=8): 3-cycle glitches -> no step; stable press -> state increments exactly 11 edges after the rise.
